// File: rtl/ts_sequence_qualifier.sv
// Counts consecutive identical TS1/TS2 ordered sets and flags when the LTSSM match count is reached.
// Optional idle-set counter is built when TSQ_IDLE_CNT_EN is defined.

package ts_sequence_qualifier_pkg;

  localparam int unsigned OS_BYTES = 16;

  typedef enum logic [2:0] {
    RATE_GEN1 = 3'd0,
    RATE_GEN2 = 3'd1,
    RATE_GEN3 = 3'd2,
    RATE_GEN4 = 3'd3,
    RATE_GEN5 = 3'd4
  } rate_speed_e;

  typedef logic [OS_BYTES*8-1:0] pcie_ordered_set_t;

  // Compare key: TS type plus bytes 1..5 (byte 1 in the low field)
  typedef struct packed {
    logic       ts_type;
    logic [7:0] training_ctrl;
    logic [7:0] rate_id;
    logic [7:0] nfts;
    logic [7:0] lane_num;
    logic [7:0] link_num;
  } ts_key_t;

endpackage

module ts_sequence_qualifier
  import ts_sequence_qualifier_pkg::*;
#(
  parameter int unsigned MATCH_COUNT = 8,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  rate_speed_e          curr_data_rate_i,
  input  pcie_ordered_set_t    ordered_set_i,
  input  logic                 ts1_valid_i,
  input  logic                 ts2_valid_i,
  input  logic                 idle_valid_i,
  input  logic                 eieos_valid_i,
  input  logic                 clear_i,
  output logic [CNT_WIDTH-1:0] ts_count_o,
  output logic                 ts_type_o,
  output logic                 ts1_match_o,
  output logic                 ts2_match_o,
  output logic                 new_ts_o,
  output logic [7:0]           link_num_o,
  output logic [7:0]           lane_num_o,
  output logic [7:0]           nfts_o,
  output logic [7:0]           rate_id_o,
  output logic [7:0]           training_ctrl_o
`ifdef TSQ_IDLE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] idle_count_o,
  output logic                 idle_match_o
`endif
);

  localparam logic [CNT_WIDTH-1:0] MATCH_CNT = CNT_WIDTH'(MATCH_COUNT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_COUNT   = 2'd1,
    ST_MATCHED = 2'd2
  } state_e;

  // A freshly started run of length 1 already satisfies a match count of 1
  localparam state_e FRESH_ST = (MATCH_COUNT == 1) ? ST_MATCHED : ST_COUNT;

  state_e               state_q, state_d;
  rate_speed_e          rate_q;
  ts_key_t              key_in, key_q, key_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 new_ts_q, new_ts_d;
  logic                 ts1_match_q, ts1_match_d;
  logic                 ts2_match_q, ts2_match_d;
  logic                 restart, ts_acc, key_eq;

  // Rate change is treated exactly like an LTSSM clear
  assign restart = clear_i | (curr_data_rate_i != rate_q);
  assign ts_acc  = (ts1_valid_i ^ ts2_valid_i) & ~restart;

  assign key_in.ts_type       = ts2_valid_i;
  assign key_in.link_num      = ordered_set_i[8  +: 8];
  assign key_in.lane_num      = ordered_set_i[16 +: 8];
  assign key_in.nfts          = ordered_set_i[24 +: 8];
  assign key_in.rate_id       = ordered_set_i[32 +: 8];
  assign key_in.training_ctrl = ordered_set_i[40 +: 8];
  assign key_eq               = (key_in == key_q);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ST_EMPTY;
    end else if (ts_acc) begin
      case (state_q)
        ST_EMPTY:   state_d = FRESH_ST;
        ST_COUNT: begin
          if (!key_eq)                         state_d = FRESH_ST;
          else if (count_q >= MATCH_CNT - CNT_ONE) state_d = ST_MATCHED;
          else                                 state_d = ST_COUNT;
        end
        ST_MATCHED: state_d = key_eq ? ST_MATCHED : FRESH_ST;
        default:    state_d = ST_EMPTY;
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    key_d    = key_q;
    count_d  = count_q;
    new_ts_d = 1'b0;
    if (restart) begin
      count_d = '0;
    end else if (ts_acc) begin
      new_ts_d = 1'b1;
      if (state_q == ST_EMPTY || !key_eq) begin
        key_d   = key_in;
        count_d = CNT_ONE;
      end else if (count_q < MATCH_CNT) begin
        count_d = count_q + CNT_ONE;
      end
    end
    ts1_match_d = (count_d == MATCH_CNT) & ~key_d.ts_type;
    ts2_match_d = (count_d == MATCH_CNT) &  key_d.ts_type;
  end

  // Output and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rate_q      <= RATE_GEN1;
      key_q       <= '0;
      count_q     <= '0;
      new_ts_q    <= 1'b0;
      ts1_match_q <= 1'b0;
      ts2_match_q <= 1'b0;
    end else begin
      rate_q      <= curr_data_rate_i;
      key_q       <= key_d;
      count_q     <= count_d;
      new_ts_q    <= new_ts_d;
      ts1_match_q <= ts1_match_d;
      ts2_match_q <= ts2_match_d;
    end
  end

  assign ts_count_o      = count_q;
  assign ts_type_o       = key_q.ts_type;
  assign ts1_match_o     = ts1_match_q;
  assign ts2_match_o     = ts2_match_q;
  assign new_ts_o        = new_ts_q;
  assign link_num_o      = key_q.link_num;
  assign lane_num_o      = key_q.lane_num;
  assign nfts_o          = key_q.nfts;
  assign rate_id_o       = key_q.rate_id;
  assign training_ctrl_o = key_q.training_ctrl;

`ifdef TSQ_IDLE_CNT_EN
  logic [CNT_WIDTH-1:0] idle_q, idle_d;
  logic                 idle_match_q;

  // Idle run length; any accepted TS or restart breaks it, EIEOS does not
  always_comb begin
    idle_d = idle_q;
    if (restart || ts_acc) begin
      idle_d = '0;
    end else if (idle_valid_i && idle_q < MATCH_CNT) begin
      idle_d = idle_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_q       <= '0;
      idle_match_q <= 1'b0;
    end else begin
      idle_q       <= idle_d;
      idle_match_q <= (idle_d == MATCH_CNT);
    end
  end

  assign idle_count_o = idle_q;
  assign idle_match_o = idle_match_q;

  logic unused_bits;
  assign unused_bits = ^{ordered_set_i[7:0], ordered_set_i[127:48], eieos_valid_i};
`else
  logic unused_bits;
  assign unused_bits = ^{ordered_set_i[7:0], ordered_set_i[127:48], eieos_valid_i, idle_valid_i};
`endif

endmodule

// File: tb/tb_ts_sequence_qualifier.sv
// Self-checking bench for ts_sequence_qualifier: directed test-plan scenarios then random traffic
// checked against a run-length reference model. Idle checks are built when TSQ_IDLE_CNT_EN is defined.

module tb_ts_sequence_qualifier;
  import ts_sequence_qualifier_pkg::*;

  localparam int unsigned M  = 8;
  localparam int unsigned CW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  rate_speed_e       rate;
  pcie_ordered_set_t os;
  logic              ts1_v, ts2_v, idle_v, eieos_v, clr;
  logic [CW-1:0]     ts_count;
  logic              ts_type, ts1_match, ts2_match, new_ts;
  logic [7:0]        link_num, lane_num, nfts, rate_id, training_ctrl;
`ifdef TSQ_IDLE_CNT_EN
  logic [CW-1:0]     idle_count;
  logic              idle_match;
`endif

  ts_sequence_qualifier #(.MATCH_COUNT(M), .CNT_WIDTH(CW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .curr_data_rate_i(rate),
    .ordered_set_i   (os),
    .ts1_valid_i     (ts1_v),
    .ts2_valid_i     (ts2_v),
    .idle_valid_i    (idle_v),
    .eieos_valid_i   (eieos_v),
    .clear_i         (clr),
    .ts_count_o      (ts_count),
    .ts_type_o       (ts_type),
    .ts1_match_o     (ts1_match),
    .ts2_match_o     (ts2_match),
    .new_ts_o        (new_ts),
    .link_num_o      (link_num),
    .lane_num_o      (lane_num),
    .nfts_o          (nfts),
    .rate_id_o       (rate_id),
    .training_ctrl_o (training_ctrl)
`ifdef TSQ_IDLE_CNT_EN
    ,
    .idle_count_o    (idle_count),
    .idle_match_o    (idle_match)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: length of the identical-TS run and the key that started it
  int          run_len;
  logic [40:0] held;
  logic        exp_new;
  rate_speed_e rate_prev;
  int          idle_len;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ts_count",      64'(ts_count),      64'(run_len));
    check("ts_type",       64'(ts_type),       64'(held[40]));
    check("ts1_match",     64'(ts1_match),     64'(run_len == int'(M) && !held[40]));
    check("ts2_match",     64'(ts2_match),     64'(run_len == int'(M) &&  held[40]));
    check("new_ts",        64'(new_ts),        64'(exp_new));
    check("link_num",      64'(link_num),      64'(held[7:0]));
    check("lane_num",      64'(lane_num),      64'(held[15:8]));
    check("nfts",          64'(nfts),          64'(held[23:16]));
    check("rate_id",       64'(rate_id),       64'(held[31:24]));
    check("training_ctrl", 64'(training_ctrl), 64'(held[39:32]));
`ifdef TSQ_IDLE_CNT_EN
    check("idle_count",    64'(idle_count),    64'(idle_len));
    check("idle_match",    64'(idle_match),    64'(idle_len == int'(M)));
`endif
  endtask

  task automatic model_reset();
    run_len   = 0;
    held      = '0;
    exp_new   = 1'b0;
    rate_prev = RATE_GEN1;
    idle_len  = 0;
  endtask

  // Byte 0 and bytes 6..15 are random filler that must never influence the compare
  function automatic pcie_ordered_set_t make_os(input logic [7:0] link, input logic [7:0] lane,
                                                input logic [7:0] nf);
    pcie_ordered_set_t o;
    o = {$urandom, $urandom, $urandom, $urandom};
    o[8  +: 8] = link;
    o[16 +: 8] = lane;
    o[24 +: 8] = nf;
    o[32 +: 8] = 8'h02;
    o[40 +: 8] = 8'h00;
    return o;
  endfunction

  // Drive one cycle, advance the model on the sampling edge, compare #1 later
  task automatic step(input logic t1, input logic t2, input logic idl, input logic eie,
                      input logic c, input rate_speed_e r, input pcie_ordered_set_t o);
    logic        restart, acc;
    logic [40:0] key;
    ts1_v = t1; ts2_v = t2; idle_v = idl; eieos_v = eie; clr = c; rate = r; os = o;
    @(posedge clk);
    restart   = c || (r != rate_prev);
    rate_prev = r;
    acc       = (t1 ^ t2) && !restart;
    key       = {t2, o[47:8]};
    exp_new   = acc;
    if (restart) begin
      run_len  = 0;
      idle_len = 0;
    end else if (acc) begin
      if (run_len == 0 || key != held) begin
        held    = key;
        run_len = 1;
      end else if (run_len < int'(M)) begin
        run_len++;
      end
      idle_len = 0;
    end else if (idl && idle_len < int'(M)) begin
      idle_len++;
    end
    #1;
    check_all();
  endtask

  task automatic ts(input logic is_ts2, input rate_speed_e r, input pcie_ordered_set_t o);
    step(!is_ts2, is_ts2, 1'b0, 1'b0, 1'b0, r, o);
  endtask

  task automatic do_clear(input rate_speed_e r);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, r, '0);
  endtask

  initial begin
    pcie_ordered_set_t a, b;
    rate_speed_e       cur_rate;
    logic              cur_type;
    logic [7:0]        cur_lane;
    int                sel;

    model_reset();
    rst_n = 1'b0;
    rate = RATE_GEN1; os = '0;
    ts1_v = 0; ts2_v = 0; idle_v = 0; eieos_v = 0; clr = 0;
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 8 TS1s: count steps 1..8, match after the 8th
    a = make_os(8'h01, 8'h00, 8'h20);
    for (int i = 0; i < 8; i++) begin
      ts(1'b0, RATE_GEN1, make_os(8'h01, 8'h00, 8'h20));
      check("s1_count", 64'(ts_count), 64'(i + 1));
    end
    check("s1_match", 64'(ts1_match), 64'd1);
    check("s1_nfts",  64'(nfts), 64'h20);
    do_clear(RATE_GEN1);

    // Lane change after 5 restarts the run; match only after the 13th strobe
    b = make_os(8'h01, 8'h03, 8'h20);
    for (int i = 0; i < 5; i++) ts(1'b0, RATE_GEN1, a);
    ts(1'b0, RATE_GEN1, b);
    check("s2_restart", 64'(ts_count), 64'd1);
    for (int i = 0; i < 6; i++) ts(1'b0, RATE_GEN1, b);
    check("s2_no_match_12", 64'(ts1_match), 64'd0);
    ts(1'b0, RATE_GEN1, b);
    check("s2_match_13", 64'(ts1_match), 64'd1);
    do_clear(RATE_GEN1);

    // TS2 run interleaved with EIEOS
    for (int i = 0; i < 4; i++) ts(1'b1, RATE_GEN1, a);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RATE_GEN1, '0);
    check("s3_eieos_hold", 64'(ts_count), 64'd4);
    for (int i = 0; i < 4; i++) ts(1'b1, RATE_GEN1, a);
    check("s3_ts2_match", 64'(ts2_match), 64'd1);
    do_clear(RATE_GEN1);

    // Clear in the same cycle as the 8th TS1
    for (int i = 0; i < 7; i++) ts(1'b0, RATE_GEN1, a);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, RATE_GEN1, a);
    check("s4_count", 64'(ts_count), 64'd0);
    check("s4_new_ts", 64'(new_ts), 64'd0);
    check("s4_match", 64'(ts1_match), 64'd0);

    // Both strobes at once are ignored
    ts(1'b0, RATE_GEN1, a);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RATE_GEN1, b);
    check("both_hold", 64'(ts_count), 64'd1);

    // Saturated run at gen2, then gen3: count drops, fields hold
    for (int i = 0; i < 10; i++) ts(1'b0, RATE_GEN2, a);
    check("s5_saturate", 64'(ts_count), 64'(M));
    ts(1'b0, RATE_GEN3, b);
    check("s5_rate_count", 64'(ts_count), 64'd0);
    check("s5_rate_match", 64'(ts1_match), 64'd0);
    check("s5_rate_lane",  64'(lane_num), 64'h00);

`ifdef TSQ_IDLE_CNT_EN
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, RATE_GEN3, '0);
    check("s6_idle_match", 64'(idle_match), 64'd1);
    ts(1'b0, RATE_GEN3, a);
    check("s6_idle_zero", 64'(idle_count), 64'd0);
`endif

    // Asynchronous reset mid-run
    for (int i = 0; i < 3; i++) ts(1'b0, RATE_GEN3, a);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rate = RATE_GEN1;
    rst_n = 1'b1;

    // Random traffic, back-to-back strobes included
    cur_rate = RATE_GEN1;
    cur_type = 1'b0;
    cur_lane = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) cur_lane = 8'($urandom_range(0, 2));
      if ($urandom_range(0, 29) == 0) cur_type = ~cur_type;
      sel = int'($urandom_range(0, 99));
      if (sel >= 98) cur_rate = rate_speed_e'(3'($urandom_range(0, 4)));
      a = make_os(8'h05, cur_lane, 8'h18);
      if (sel < 60)      ts(cur_type, cur_rate, a);
      else if (sel < 64) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cur_rate, a);
      else if (sel < 72) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cur_rate, a);
      else if (sel < 90) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cur_rate, a);
      else if (sel < 92) step(!cur_type, cur_type, 1'b0, 1'b0, 1'b1, cur_rate, a);
      else               step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_rate, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ts_sequence_qualifier.md
# ts_sequence_qualifier

Receive-side stage that sits directly downstream of the ordered-set decoder. It consumes the decoded 16-byte ordered set and its TS1/TS2/IDLE/EIEOS valid strobes. It counts consecutive identical training sets and holds the field values of the current run. It flags when the LTSSM's consecutive-match requirement is met, e.g. 8 identical TS1s in Polling.Active or 8 identical TS2s in Configuration.Complete.

## Interface
Parameters:
- MATCH_COUNT, 8: consecutive identical TSs needed to assert a match flag; legal range 1..255.
- CNT_WIDTH, 8: width of count outputs; must satisfy CNT_WIDTH >= $clog2(MATCH_COUNT+1).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- curr_data_rate_i  input  rate_speed_e  current link rate.
- ordered_set_i  input  pcie_ordered_set_t  decoded ordered set; byte k at bits [8k+:8].
- ts1_valid_i  input  1  single-cycle strobe: ordered_set_i is a TS1.
- ts2_valid_i  input  1  single-cycle strobe: ordered_set_i is a TS2.
- idle_valid_i  input  1  single-cycle strobe: idle/EIOS set received.
- eieos_valid_i  input  1  single-cycle strobe: EIEOS received.
- clear_i  input  1  LTSSM state change; restarts all counting.
- ts_count_o  output  CNT_WIDTH  length of the current identical-TS run, saturating at MATCH_COUNT.
- ts_type_o  output  1  type of the held run: 0 = TS1, 1 = TS2.
- ts1_match_o  output  1  level; ts_count_o == MATCH_COUNT and ts_type_o == 0.
- ts2_match_o  output  1  level; ts_count_o == MATCH_COUNT and ts_type_o == 1.
- new_ts_o  output  1  one-cycle pulse per accepted TS.
- link_num_o, lane_num_o, nfts_o, rate_id_o, training_ctrl_o  output  8 each  held bytes 1..5 of the current run.
- idle_count_o  output  CNT_WIDTH  consecutive idle sets; present only with TSQ_IDLE_CNT_EN.
- idle_match_o  output  1  idle_count_o == MATCH_COUNT; present only with TSQ_IDLE_CNT_EN.

## Operation
- A TS is accepted when exactly one of ts1_valid_i or ts2_valid_i is high and clear_i is low.
- If both strobes are high in the same cycle, the strobes are ignored and all state holds.
- The compare key is {type, bytes 1..5}. Byte offsets are identical at all rates: at Gen1/2 byte 0 is COM, at Gen3 byte 0 is the TS identifier, and byte 0 is never compared.
- The FSM has three states: ST_EMPTY, ST_COUNT and ST_MATCHED.
- ST_EMPTY: on an accepted TS, capture the key, set the count to 1 and go to ST_COUNT. If MATCH_COUNT == 1, go directly to ST_MATCHED.
- ST_COUNT: on an accepted TS whose key equals the held key, increment the count. When the count reaches MATCH_COUNT, go to ST_MATCHED.
- ST_COUNT: on an accepted TS whose key differs, recapture the key, set the count to 1 and stay in ST_COUNT.
- ST_MATCHED: on an equal key, the count stays at MATCH_COUNT (saturated). On a differing key, recapture the key, set the count to 1 and go to ST_COUNT.
- eieos_valid_i never breaks or advances a run, because EIEOS interleaves TS sets during Gen3 training.
- A rate change is detected when curr_data_rate_i differs from its value registered last cycle. It behaves exactly like clear_i.
- clear_i or a rate change forces ST_EMPTY, zeroes both counts and holds the field outputs at their last values. Any strobe in that same cycle is discarded.

## Timing
- All outputs are registered.
- State, counts, fields and match flags update on the clock edge that samples the accepted strobe, so they are visible 1 cycle after the strobe.
- new_ts_o is high for exactly that one cycle.
- Reset values: state ST_EMPTY, all counts 0, ts_type_o 0, match flags 0, new_ts_o 0, all field outputs 0, registered rate = gen1.
- Reset asserted mid-run returns all outputs to their reset values asynchronously.
- Back-to-back strobes, one per cycle, must be supported with no bubble.

## Configuration
- Macro TSQ_IDLE_CNT_EN.
- Defined: an idle counter is built. idle_valid_i increments it, saturating at MATCH_COUNT, and drives idle_count_o and idle_match_o.
- Defined: any accepted TS zeroes the idle counter. clear_i and a rate change also zero it. EIEOS leaves it unchanged.
- Undefined: the idle counter, idle_count_o and idle_match_o are absent, and idle_valid_i is ignored.

## Test plan
- 8 TS1s, link 0x01, lane 0x00, nfts 0x20 -> ts_count_o steps 1..8; ts1_match_o = 1 one cycle after the 8th; nfts_o = 0x20.
- 5 TS1s, then 1 TS1 with lane 0x03, then 7 more with lane 0x03 -> count drops to 1 then reaches 8; ts1_match_o asserts only after the 13th strobe.
- 4 TS2s, EIEOS strobe, 4 TS2s -> count reaches 8 and ts2_match_o = 1; EIEOS causes no reset.
- 7 TS1s, then clear_i in the same cycle as the 8th strobe -> count 0, state ST_EMPTY, no match, new_ts_o stays 0.
- Saturated run, then curr_data_rate_i changes gen2 -> gen3 -> count 0 and ts1_match_o drops the next cycle; field outputs hold their values.
- With TSQ_IDLE_CNT_EN: 8 idle strobes -> idle_match_o = 1; one TS1 -> idle_count_o = 0.
